// File: rtl/data_mem_responder_if.sv
// Request/response bus between a memory consumer and data_mem_responder.
interface data_mem_responder_if;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LANES-1:0]  do_read;
        logic [LANES-1:0]  do_write;
    } memory_io_req;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } memory_io_rsp;

    memory_io_req data_mem_req;
    memory_io_rsp data_mem_rsp;

    modport master (output data_mem_req, input data_mem_rsp);
    modport slave  (input data_mem_req, output data_mem_rsp);

endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte-lane writes, optional zero-fill after
// reset, and a fixed-latency in-order response pipeline (no back-pressure).
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  init_idx_q;
    logic [IDX_W-1:0]  init_idx_d;
    logic              init_we_c;
    logic              ready_q;

    logic [DATA_W-1:0] storage [DEPTH_WORDS];

    logic              accept_c;
    logic              do_rd_c;
    logic              do_wr_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic [DATA_W-1:0] rd_word_c;
    stage_t            stage_in_c;
    stage_t            pipe_q [LATENCY];

    // Request decode: word index ignores the byte offset and wraps on depth.
    always_comb begin
        do_rd_c   = |bus.data_mem_req.do_read;
        do_wr_c   = |bus.data_mem_req.do_write;
        req_idx_c = bus.data_mem_req.addr[IDX_W+1:2];
        accept_c  = ready_q & bus.data_mem_req.valid & (do_rd_c | do_wr_c);
        rd_word_c = storage[req_idx_c];
    end

    // FSM next state: INIT walks the zero-fill index, RUN serves requests.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        init_we_c  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_we_c = 1'b1;
                if (init_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d    = ST_RUN;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state, init index and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT_ZERO ? ST_INIT : ST_RUN;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ready_q    <= (state_d == ST_RUN);
        end
    end

    // Storage: zero-fill during INIT, byte-lane writes on accepted requests.
    always_ff @(posedge clk) begin
        if (init_we_c) begin
            storage[init_idx_q] <= '0;
        end else if (accept_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (bus.data_mem_req.do_write[i]) begin
                    storage[req_idx_c][8*i +: 8] <= bus.data_mem_req.data[8*i +: 8];
                end
            end
        end
    end

    // Pipeline entry: read data is the pre-write word, zero for write-only.
    always_comb begin
        stage_in_c = '0;
        if (accept_c) begin
            stage_in_c.valid = 1'b1;
            stage_in_c.addr  = bus.data_mem_req.addr;
            if (do_rd_c) begin
                stage_in_c.data = rd_word_c;
            end
        end
    end

    // Response shift register; idle stages carry zeros so outputs stay clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_in_c;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Response fields come from the last pipeline stage only.
    always_comb begin
        bus.data_mem_rsp.valid = pipe_q[LATENCY-1].valid;
        bus.data_mem_rsp.ready = ready_q;
        bus.data_mem_rsp.addr  = pipe_q[LATENCY-1].addr;
        bus.data_mem_rsp.data  = pipe_q[LATENCY-1].data;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: two responders (zero-fill/latency 2 and no-init/latency 4) driven by
// the same request stream, compared cycle by cycle against a reference model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 4;
    localparam int unsigned RING  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .INIT_ZERO(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B), .INIT_ZERO(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] m;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    exp_t        sched [2][RING];
    logic [31:0] mem_m [2][DEPTH];
    logic [3:0]  known [2][DEPTH];
    int unsigned since_rst [2];
    bit          started;
    bit          prev_rst;
    int unsigned cyc;
    int          checks;
    int          passes;

    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int unsigned thr_of(input int i);
        return (i == 0) ? DEPTH : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input logic [31:0] mask);
        checks++;
        if (((act ^ exp) & mask) === 32'h0) passes++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h mask=%h", name, cyc, act, exp, mask);
    endtask

    task automatic get_rsp(input int i, output logic v, output logic r,
                           output logic [31:0] a, output logic [31:0] d);
        if (i == 0) begin
            v = ifa.data_mem_rsp.valid; r = ifa.data_mem_rsp.ready;
            a = ifa.data_mem_rsp.addr;  d = ifa.data_mem_rsp.data;
        end else begin
            v = ifb.data_mem_rsp.valid; r = ifb.data_mem_rsp.ready;
            a = ifb.data_mem_rsp.addr;  d = ifb.data_mem_rsp.data;
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, update model.
    task automatic tick(input logic rst, input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] rd, input logic [3:0] wr);
        logic        rv, rr;
        logic [31:0] ra, rdt;
        exp_t        e;
        int unsigned idx, slot;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (prev_rst) begin
                since_rst[i] = 0;
                for (int r = 0; r < int'(RING); r++) begin
                    sched[i][r].v = 1'b0; sched[i][r].a = '0;
                    sched[i][r].d = '0;   sched[i][r].m = '1;
                end
                for (int w = 0; w < int'(DEPTH); w++) begin
                    if (i == 0) begin
                        mem_m[i][w] = '0; known[i][w] = 4'hF;
                    end else begin
                        known[i][w] = 4'h0;
                    end
                end
            end else begin
                since_rst[i]++;
            end
        end
        if (prev_rst) started = 1'b1;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                get_rsp(i, rv, rr, ra, rdt);
                e = sched[i][cyc % RING];
                check($sformatf("dut%0d_valid", i), 32'(rv), 32'(e.v), 32'h1);
                check($sformatf("dut%0d_ready", i), 32'(rr), 32'(since_rst[i] >= thr_of(i)), 32'h1);
                check($sformatf("dut%0d_addr", i), ra, e.a, 32'hFFFF_FFFF);
                check($sformatf("dut%0d_data", i), rdt, e.d, e.m);
                sched[i][cyc % RING].v = 1'b0; sched[i][cyc % RING].a = '0;
                sched[i][cyc % RING].d = '0;   sched[i][cyc % RING].m = '1;
            end
        end
        reset = rst;
        ifa.data_mem_req.valid = v;  ifb.data_mem_req.valid = v;
        ifa.data_mem_req.addr = a;   ifb.data_mem_req.addr = a;
        ifa.data_mem_req.data = d;   ifb.data_mem_req.data = d;
        ifa.data_mem_req.do_read = rd;  ifb.data_mem_req.do_read = rd;
        ifa.data_mem_req.do_write = wr; ifb.data_mem_req.do_write = wr;
        prev_rst = rst;
        if (!rst && v && (rd != 4'h0 || wr != 4'h0)) begin
            for (int i = 0; i < 2; i++) begin
                if (since_rst[i] >= thr_of(i)) begin
                    idx  = (a >> 2) % DEPTH;
                    slot = (cyc + lat_of(i)) % RING;
                    sched[i][slot].v = 1'b1;
                    sched[i][slot].a = a;
                    if (rd != 4'h0) begin
                        sched[i][slot].d = mem_m[i][idx];
                        sched[i][slot].m = {{8{known[i][idx][3]}}, {8{known[i][idx][2]}},
                                            {8{known[i][idx][1]}}, {8{known[i][idx][0]}}};
                    end else begin
                        sched[i][slot].d = '0;
                        sched[i][slot].m = '1;
                    end
                    for (int l = 0; l < 4; l++) begin
                        if (wr[l]) begin
                            mem_m[i][idx][8*l +: 8] = d[8*l +: 8];
                            known[i][idx][l] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    // Count cycles with dut_a ready low after reset release; bounded.
    task automatic count_init(input string name);
        int n;
        n = 0;
        idle();
        while (ifa.data_mem_rsp.ready !== 1'b1 && n < 40) begin
            n++;
            idle();
        end
        check(name, 32'(n), 32'd16, 32'hFFFF_FFFF);
    endtask

    vec_t        vecs [15];
    logic [31:0] b2b_addr [8];
    logic [31:0] b2b_data [8];

    initial begin
        vecs[0]  = '{32'h0000_003C, 32'h0,         4'hF, 4'h0, 1'b1, 32'h0};
        vecs[1]  = '{32'h0000_0100, 32'hDEAD_BEEF, 4'h0, 4'hF, 1'b1, 32'h0};
        vecs[2]  = '{32'h0000_0100, 32'h0,         4'hF, 4'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{32'h0000_0008, 32'h1122_3344, 4'h0, 4'hF, 1'b1, 32'h0};
        vecs[4]  = '{32'h0000_0008, 32'h00AA_0000, 4'h0, 4'h4, 1'b1, 32'h0};
        vecs[5]  = '{32'h0000_0008, 32'h0,         4'hF, 4'h0, 1'b1, 32'h11AA_3344};
        vecs[6]  = '{32'h0000_000C, 32'h1234_5678, 4'h0, 4'hF, 1'b1, 32'h0};
        vecs[7]  = '{32'h0000_000C, 32'hCAFE_F00D, 4'hF, 4'hF, 1'b1, 32'h1234_5678};
        vecs[8]  = '{32'h0000_000C, 32'h0,         4'hF, 4'h0, 1'b1, 32'hCAFE_F00D};
        vecs[9]  = '{32'h0000_0048, 32'h0,         4'hF, 4'h0, 1'b1, 32'h11AA_3344};
        vecs[10] = '{32'h0000_000C, 32'h0,         4'h0, 4'h0, 1'b0, 32'h0};
        vecs[11] = '{32'h0000_000D, 32'h0,         4'h1, 4'h0, 1'b1, 32'hCAFE_F00D};
        vecs[12] = '{32'h0000_0010, 32'h0000_0005, 4'h0, 4'hF, 1'b1, 32'h0};
        vecs[13] = '{32'h0000_0050, 32'h0,         4'hF, 4'h0, 1'b1, 32'h0000_0005};
        vecs[14] = '{32'hFFFF_FF08, 32'h0,         4'hF, 4'h0, 1'b1, 32'h11AA_3344};

        b2b_addr = '{32'h08, 32'h48, 32'h0C, 32'h0D, 32'h100, 32'h10, 32'h50, 32'hFFFF_FF08};
        b2b_data = '{32'h11AA_3344, 32'h11AA_3344, 32'hCAFE_F00D, 32'hCAFE_F00D,
                     32'hFEED_FACE, 32'h5, 32'h5, 32'h11AA_3344};

        checks = 0; passes = 0; cyc = 0;
        started = 1'b0; prev_rst = 1'b1;
        reset = 1'b1;
        ifa.data_mem_req = '0;
        ifb.data_mem_req = '0;

        repeat (3) tick(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        count_init("init_ready_cycles");

        // Directed transactions, one at a time, checked on dut_a.
        for (int k = 0; k < 15; k++) begin
            tick(1'b0, 1'b1, vecs[k].addr, vecs[k].data, vecs[k].rd, vecs[k].wr);
            repeat (LAT_A) idle();
            check($sformatf("vec%0d_valid", k), 32'(ifa.data_mem_rsp.valid), 32'(vecs[k].exp_v), 32'h1);
            check($sformatf("vec%0d_addr", k), ifa.data_mem_rsp.addr,
                  vecs[k].exp_v ? vecs[k].addr : 32'h0, 32'hFFFF_FFFF);
            check($sformatf("vec%0d_data", k), ifa.data_mem_rsp.data, vecs[k].exp_d, 32'hFFFF_FFFF);
        end
        repeat (4) idle();

        // Write then read of the same word on consecutive cycles.
        tick(1'b0, 1'b1, 32'h100, 32'hFEED_FACE, 4'h0, 4'hF);
        tick(1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 4'h0);
        idle();
        check("raw_wr_valid", 32'(ifa.data_mem_rsp.valid), 32'h1, 32'h1);
        check("raw_wr_data", ifa.data_mem_rsp.data, 32'h0, 32'hFFFF_FFFF);
        idle();
        check("raw_rd_valid", 32'(ifa.data_mem_rsp.valid), 32'h1, 32'h1);
        check("raw_rd_addr", ifa.data_mem_rsp.addr, 32'h100, 32'hFFFF_FFFF);
        check("raw_rd_data", ifa.data_mem_rsp.data, 32'hFEED_FACE, 32'hFFFF_FFFF);
        repeat (5) idle();

        // Eight back-to-back reads.
        for (int j = 0; j < 13; j++) begin
            if (j < 8) tick(1'b0, 1'b1, b2b_addr[j], 32'h0, 4'hF, 4'h0);
            else idle();
            if (j >= 4 && j < 12) begin
                check($sformatf("b2b_b_valid%0d", j), 32'(ifb.data_mem_rsp.valid), 32'h1, 32'h1);
                check($sformatf("b2b_b_addr%0d", j), ifb.data_mem_rsp.addr, b2b_addr[j-4], 32'hFFFF_FFFF);
                check($sformatf("b2b_b_data%0d", j), ifb.data_mem_rsp.data, b2b_data[j-4], 32'hFFFF_FFFF);
            end else begin
                check($sformatf("b2b_b_idle%0d", j), 32'(ifb.data_mem_rsp.valid), 32'h0, 32'h1);
            end
            if (j >= 2 && j < 10)
                check($sformatf("b2b_a_addr%0d", j), ifa.data_mem_rsp.addr, b2b_addr[j-2], 32'hFFFF_FFFF);
        end

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            tick(1'b0, ($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
        end
        repeat (5) idle();

        // Reset while two reads are in flight in dut_b.
        tick(1'b0, 1'b1, 32'h08, 32'h0, 4'hF, 4'h0);
        tick(1'b0, 1'b1, 32'h0C, 32'h0, 4'hF, 4'h0);
        tick(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        for (int j = 0; j < 6; j++) begin
            idle();
            check($sformatf("rst_flight_b%0d", j), 32'(ifb.data_mem_rsp.valid), 32'h0, 32'h1);
        end
        repeat (3) tick(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        count_init("reinit_ready_cycles");

        for (int n = 0; n < 150; n++) begin
            tick(1'b0, ($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
        end
        repeat (6) idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 32-bit words stored; power of two.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response valid; legal range 1..4.
REQ-003 Parameter INIT_ZERO, default 1: 1 selects a zero-fill INIT phase after reset; 0 skips it.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_mem_req  input  memory_io_req  fields: valid, addr[31:0], data[31:0], do_read[3:0], do_write[3:0].
REQ-007 data_mem_rsp  output  memory_io_rsp  fields: valid, ready, addr[31:0], data[31:0].

Function
REQ-008 FSM states: INIT and RUN. Reset enters INIT when INIT_ZERO=1 and RUN when INIT_ZERO=0.
REQ-009 INIT: one word per cycle written to zero, index counter 0..DEPTH_WORDS-1; after the write at DEPTH_WORDS-1, the next state is RUN.
REQ-010 data_mem_rsp.ready: 0 in INIT, 1 in RUN; registered output.
REQ-011 Acceptance: a request is accepted in a cycle with ready=1, valid=1 and (|do_read or |do_write); a valid request with both masks zero is discarded with no response.
REQ-012 Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap modulo DEPTH_WORDS); addr[1:0] ignored for storage.
REQ-013 Write: on acceptance, byte lane i (bits 8i+7:8i) of the indexed word is updated from req.data when do_write[i]=1; other lanes are unchanged.
REQ-014 Read: on acceptance, the full 32-bit word is sampled before that cycle's write; lane alignment and sign extension belong to the consumer.
REQ-015 Response: every accepted request produces exactly one rsp.valid=1 pulse, exactly LATENCY cycles after the acceptance edge.
REQ-016 rsp.addr = accepted req.addr (all 32 bits, unmodified); rsp.data = sampled word when do_read≠0, else 32'h0.
REQ-017 Responses are delivered in order, one per cycle maximum; back-to-back acceptance yields back-to-back responses (throughput 1/cycle).
REQ-018 The response path has no back-pressure; the consumer must accept every response in its valid cycle.
REQ-019 Ordering: a read accepted in any cycle after a write to the same word returns the written data.
REQ-020 Combined request (do_read≠0 and do_write≠0): returns the old word, then commits the write.
REQ-021 The in-flight response pipeline is a LATENCY-deep shift register of {valid, addr, data}; rsp fields are driven from its last stage only.
REQ-022 rsp.addr and rsp.data are 0 whenever rsp.valid=0.

Reset
REQ-023 On reset=1 at an edge: rsp.valid=0, rsp.addr=0, rsp.data=0, rsp.ready=0, and all pipeline stage valids are cleared.
REQ-024 Reset during RUN with requests in flight: no pending response is emitted after the reset edge, and storage contents are unspecified until INIT completes.
REQ-025 Reset during INIT restarts the counter at 0.
REQ-026 When INIT_ZERO=0, ready=1 on the first cycle after reset is deasserted; storage contents are unspecified.

Verification
REQ-027 INIT_ZERO=1, DEPTH_WORDS=16: release reset -> ready=0 for exactly 16 cycles, then 1; a read of addr 0x3C returns 32'h0.
REQ-028 LATENCY=2: write 0xDEADBEEF to 0x100 with do_write=4'hF, then read 0x100 next cycle -> write response data 0 at T+2; read rsp.valid at T+3 with data 0xDEADBEEF and addr 0x100.
REQ-029 Byte-lane write: word holds 0x11223344; do_write=4'b0100 with data 0x00AA0000 -> read returns 0x11AA3344.
REQ-030 Combined read+write to a word holding 0x12345678 with new data 0xCAFEF00D and both masks 4'hF -> response data 0x12345678; a subsequent read returns 0xCAFEF00D.
REQ-031 Back-to-back: 8 reads on consecutive cycles with LATENCY=4 -> 8 consecutive rsp.valid cycles starting 4 cycles after the first, in the issued addr order. Addresses DEPTH_WORDS*4+8 and 8 alias to the same word.
REQ-032 Reset asserted while 2 reads are in flight -> rsp.valid never asserts for them; ready=0 until INIT completes.
